// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
//
// Shared definitions for the up/down hex display counter:
//   digit_t          - one BCD/hex digit (4-bit nibble)
//   count_dir_e      - count direction encoding matching the DIR input
//   SEG_LUT[16]      - active-low seven-segment patterns, segment order gfedcba
//   SEG_BLANK        - all segments off
//   SEG_ZERO         - pattern for "0", also the reset value of every digit
//   prescale_period  - clock cycles per count tick, never less than 1
// -----------------------------------------------------------------------------
package updown_counter_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Integer division of the clock by the tick rate; a tick rate above the
    // clock rate (or a nonsensical zero rate) degenerates to a tick every cycle.
    function automatic int prescale_period(input longint clk_freq, input longint tick_hz);
        longint p;
        if (tick_hz <= 0) begin
            return 1;
        end
        p = clk_freq / tick_hz;
        return (p < 1) ? 1 : int'(p);
    endfunction

endpackage

// File: rtl/updown_counter_hex_n_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
//
// Combinational nibble to active-low seven-segment decoder (gfedcba).
// Ports:
//   value  in   4  digit to display (0..F)
//   blank  in   1  1 = turn every segment off
//   seg    out  7  active-low segment pattern
// -----------------------------------------------------------------------------
module seg7_decoder
    import updown_counter_pkg::*;
(
    input  digit_t     value,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_LUT[value];

endmodule

// File: rtl/updown_counter_hex_n.sv
// -----------------------------------------------------------------------------
// updown_counter_hex_n
//
// DIGITS-digit up/down counter in base 10 or 16 with a clock-derived
// prescaler tick, synchronous load, count enable, a registered wrap pulse and
// registered active-low seven-segment outputs.
//
// Parameters:
//   CLK_FREQ  clock frequency in Hz
//   TICK_HZ   count rate in Hz (prescaler period = CLK_FREQ/TICK_HZ, min 1)
//   DIGITS    number of display digits, 1..8
//   BASE      digit radix, 10 or 16 only
//
// Ports:
//   CLK       in   1         system clock
//   RST       in   1         synchronous reset, active-low
//   ENA       in   1         count enable, sampled on the prescaler tick
//   DIR       in   1         1 = count up, 0 = count down
//   LOAD      in   1         synchronous load strobe (beats a coincident tick)
//   LOAD_VAL  in   4*DIGITS  load value, digit 0 in [3:0]
//   COUNT     out  4*DIGITS  current count, digit 0 in [3:0]
//   WRAP      out  1         one-cycle pulse after a full-range wrap
//   HEX       out  7*DIGITS  active-low segments, digit 0 in [6:0]
//
// Build option:
//   UPDOWN_COUNTER_BLANK_LEADING_ZERO_EN - when defined, zero digits above the
//   most significant nonzero digit are blanked (digit 0 always shows).
// -----------------------------------------------------------------------------
module updown_counter_hex_n
    import updown_counter_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 2,
    parameter int BASE     = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENA,
    input  logic                  DIR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic                  WRAP,
    output logic [7*DIGITS-1:0]   HEX
);

    if (BASE != 10 && BASE != 16) begin : g_bad_base
        $error("updown_counter_hex_n: BASE must be 10 or 16");
    end

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("updown_counter_hex_n: DIGITS must be in 1..8");
    end

    localparam int             PERIOD    = prescale_period(CLK_FREQ, TICK_HZ);
    localparam int             PW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0]  LAST      = PW'(PERIOD - 1);
    localparam digit_t         MAX_DIGIT = digit_t'(BASE - 1);

    logic [PW-1:0]               prescaler;
    logic                        tick;
    digit_t [DIGITS-1:0]         count_q;
    digit_t [DIGITS-1:0]         count_step;
    digit_t [DIGITS-1:0]         load_clamped;
    logic                        carry_out;
    logic [DIGITS-1:0]           blank;
    logic [DIGITS-1:0][6:0]      seg_next;
    logic [DIGITS-1:0][6:0]      hex_q;

    assign tick = (prescaler == LAST);

    // Ripple carry/borrow through the digit chain. A carry that survives the
    // top digit means every digit rolled over, which is exactly a full wrap.
    always_comb begin : p_step
        logic carry;
        carry      = 1'b1;
        count_step = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (DIR == DIR_UP) begin
                    if (count_q[i] == MAX_DIGIT) begin
                        count_step[i] = '0;
                    end else begin
                        count_step[i] = count_q[i] + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        count_step[i] = MAX_DIGIT;
                    end else begin
                        count_step[i] = count_q[i] - 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        carry_out = carry;
    end

    // Out-of-range load nibbles saturate so a base-10 count never holds A..F.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[i] = (LOAD_VAL[4*i +: 4] > MAX_DIGIT) ? MAX_DIGIT
                                                               : LOAD_VAL[4*i +: 4];
        end
    end

`ifdef UPDOWN_COUNTER_BLANK_LEADING_ZERO_EN
    // Scan from the top digit down; blanking stops at the first nonzero digit.
    always_comb begin : p_blank
        logic leading;
        leading = 1'b1;
        blank   = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (count_q[i] != '0) begin
                leading = 1'b0;
            end
            blank[i] = leading;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .value (count_q[g]),
            .blank (blank[g]),
            .seg   (seg_next[g])
        );
    end

    // HEX follows COUNT by one register stage; WRAP is registered alongside
    // COUNT so both appear on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prescaler <= '0;
            count_q   <= '0;
            WRAP      <= 1'b0;
            hex_q     <= {DIGITS{SEG_ZERO}};
        end else begin
            hex_q <= seg_next;
            if (LOAD) begin
                count_q   <= load_clamped;
                prescaler <= '0;
                WRAP      <= 1'b0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick && ENA) begin
                    count_q <= count_step;
                    WRAP    <= carry_out;
                end else begin
                    WRAP    <= 1'b0;
                end
            end
        end
    end

    assign COUNT = count_q;
    assign HEX   = hex_q;

endmodule

// File: tb/tb_updown_counter_hex_n.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_hex_n
//
// Drives a BASE=10 and a BASE=16 instance (CLK_FREQ=4, TICK_HZ=1, DIGITS=2)
// from the same inputs. Stimulus pushes hand-computed expectations, tagged
// with the clock cycle they belong to, into a scoreboard queue; a monitor on
// the falling edge pops every entry due in that cycle and compares.
// -----------------------------------------------------------------------------
module tb_updown_counter_hex_n;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SF = 7'b0001110;
`ifdef UPDOWN_COUNTER_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] HI0 = 7'b1111111;
`else
    localparam logic [6:0] HI0 = 7'b1000000;
`endif

    typedef struct {
        int          cyc;
        int          unit;
        logic [95:0] name;
        logic [7:0]  cnt;
        logic        wrap;
        bit          chk_hex;
        logic [13:0] hex;
    } exp_t;

    exp_t sb[$];

    int cyc           = 0;
    int n_vectors     = 0;
    int n_miscompares = 0;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        ena      = 1'b0;
    logic        dir      = 1'b1;
    logic        load     = 1'b0;
    logic [7:0]  load_val = 8'h00;

    logic [7:0]  count10, count16;
    logic        wrap10, wrap16;
    logic [13:0] hex10, hex16;

    updown_counter_hex_n #(
        .CLK_FREQ (4),
        .TICK_HZ  (1),
        .DIGITS   (2),
        .BASE     (10)
    ) dut10 (
        .CLK      (clk),
        .RST      (rst),
        .ENA      (ena),
        .DIR      (dir),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .COUNT    (count10),
        .WRAP     (wrap10),
        .HEX      (hex10)
    );

    updown_counter_hex_n #(
        .CLK_FREQ (4),
        .TICK_HZ  (1),
        .DIGITS   (2),
        .BASE     (16)
    ) dut16 (
        .CLK      (clk),
        .RST      (rst),
        .ENA      (ena),
        .DIR      (dir),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .COUNT    (count16),
        .WRAP     (wrap16),
        .HEX      (hex16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation still running, required finished");
        $fatal(1);
    end

    task automatic applyStimulus(input logic r, input logic e, input logic d,
                                 input logic l, input logic [7:0] v);
        rst      = r;
        ena      = e;
        dir      = d;
        load     = l;
        load_val = v;
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int off, input int unit, input logic [95:0] name,
                        input logic [7:0] cnt, input logic wrap,
                        input bit chk_hex, input logic [13:0] hex);
        exp_t e;
        e.cyc     = cyc + off;
        e.unit    = unit;
        e.name    = name;
        e.cnt     = cnt;
        e.wrap    = wrap;
        e.chk_hex = chk_hex;
        e.hex     = hex;
        sb.push_back(e);
    endtask

    task automatic push_both(input int off, input logic [95:0] name,
                             input logic [7:0] cnt, input logic wrap,
                             input bit chk_hex, input logic [13:0] hex);
        push(off, 0, name, cnt, wrap, chk_hex, hex);
        push(off, 1, name, cnt, wrap, chk_hex, hex);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0]  ac;
        logic        aw;
        logic [13:0] ah;
        if (e.unit == 0) begin
            ac = count10; aw = wrap10; ah = hex10;
        end else begin
            ac = count16; aw = wrap16; ah = hex16;
        end
        n_vectors++;
        if (e.cyc != cyc) begin
            n_miscompares++;
            $display("[TB] FAIL %0s u%0d timing: checked at cycle %0d, required %0d",
                     e.name, e.unit, cyc, e.cyc);
        end
        n_vectors++;
        if (ac !== e.cnt) begin
            n_miscompares++;
            $display("[TB] FAIL %0s u%0d @%0d COUNT: got %h, want %h",
                     e.name, e.unit, cyc, ac, e.cnt);
        end
        n_vectors++;
        if (aw !== e.wrap) begin
            n_miscompares++;
            $display("[TB] FAIL %0s u%0d @%0d WRAP: got %b, want %b",
                     e.name, e.unit, cyc, aw, e.wrap);
        end
        if (e.chk_hex) begin
            n_vectors++;
            if (ah !== e.hex) begin
                n_miscompares++;
                $display("[TB] FAIL %0s u%0d @%0d HEX: got %b, want %b",
                         e.name, e.unit, cyc, ah, e.hex);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                e = sb[i];
                sb.delete(i);
                checkOutput(e);
            end
        end
    end

    initial begin
        // Reset held for three edges, then release with counting enabled.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(3);
        push_both(0, "reset", 8'h00, 1'b0, 1'b1, {S0, S0});
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        push_both(1, "rel1",    8'h00, 1'b0, 1'b1, {HI0, S0});
        push_both(3, "rel3",    8'h00, 1'b0, 1'b0, 14'h0);
        push_both(4, "step1",   8'h01, 1'b0, 1'b0, 14'h0);
        push_both(5, "step1hx", 8'h01, 1'b0, 1'b1, {HI0, S1});
        cycle(6);

        // Up count through the wrap boundary.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h98);
        push(1,  0, "up98",   8'h98, 1'b0, 1'b0, 14'h0);
        push(2,  0, "up98hx", 8'h98, 1'b0, 1'b1, {S9, S8});
        push(5,  0, "up99",   8'h99, 1'b0, 1'b0, 14'h0);
        push(6,  0, "up99hx", 8'h99, 1'b0, 1'b1, {S9, S9});
        push(8,  0, "up99b",  8'h99, 1'b0, 1'b0, 14'h0);
        push(9,  0, "upwrap", 8'h00, 1'b1, 1'b1, {S9, S9});
        push(10, 0, "upwrp2", 8'h00, 1'b0, 1'b1, {HI0, S0});
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h98);
        cycle(9);

        // Down count with borrow.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
        push(1, 0, "dn10",   8'h10, 1'b0, 1'b0, 14'h0);
        push(5, 0, "dn09",   8'h09, 1'b0, 1'b0, 14'h0);
        push(6, 0, "dn09hx", 8'h09, 1'b0, 1'b1, {HI0, S9});
        push(9, 0, "dn08",   8'h08, 1'b0, 1'b0, 14'h0);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        cycle(9);

        // Down from all-zero wraps to all-nine.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        push(1, 0, "dn00",   8'h00, 1'b0, 1'b0, 14'h0);
        push(5, 0, "dnwrap", 8'h99, 1'b1, 1'b0, 14'h0);
        push(6, 0, "dnwrp2", 8'h99, 1'b0, 1'b1, {S9, S9});
        push(9, 0, "dn98",   8'h98, 1'b0, 1'b0, 14'h0);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(9);

        // Enable low across three tick periods: count frozen, no wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            push(k, 0, "enahold", 8'h98, 1'b0, 1'b0, 14'h0);
        end
        cycle(12);

        // Load lands on the tick cycle: load wins, no step, no wrap.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
        push(1, 0, "pri99",  8'h99, 1'b0, 1'b0, 14'h0);
        push(4, 0, "pri99b", 8'h99, 1'b0, 1'b0, 14'h0);
        push(5, 0, "pri42",  8'h42, 1'b0, 1'b0, 14'h0);
        push(6, 0, "pri42b", 8'h42, 1'b0, 1'b0, 14'h0);
        push(8, 0, "pri42c", 8'h42, 1'b0, 1'b0, 14'h0);
        push(9, 0, "pri43",  8'h43, 1'b0, 1'b0, 14'h0);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
        cycle(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h42);
        cycle(5);

        // Load clamping in base 10, passthrough in base 16.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hAF);
        push(1, 0, "clmpAF",  8'h99, 1'b0, 1'b0, 14'h0);
        push(1, 1, "clmpAF",  8'hAF, 1'b0, 1'b0, 14'h0);
        push(2, 0, "clmp5C",  8'h59, 1'b0, 1'b1, {S9, S9});
        push(2, 1, "clmp5C",  8'h5C, 1'b0, 1'b1, {SA, SF});
        push(3, 0, "clmp5Ch", 8'h59, 1'b0, 1'b1, {S5, S9});
        push(3, 1, "clmp5Ch", 8'h5C, 1'b0, 1'b1, {S5, SC});
        cycle(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h5C);
        cycle(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h5C);
        cycle(2);

        // Up wrap from the top value in both radices.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        push(1, 0, "topld",   8'h99, 1'b0, 1'b0, 14'h0);
        push(1, 1, "topld",   8'hFF, 1'b0, 1'b0, 14'h0);
        push(2, 1, "topldhx", 8'hFF, 1'b0, 1'b1, {SF, SF});
        push(4, 1, "toppre",  8'hFF, 1'b0, 1'b1, {SF, SF});
        push(5, 0, "topwrap", 8'h00, 1'b1, 1'b0, 14'h0);
        push(5, 1, "topwrap", 8'h00, 1'b1, 1'b1, {SF, SF});
        push(6, 0, "topwrp2", 8'h00, 1'b0, 1'b1, {HI0, S0});
        push(6, 1, "topwrp2", 8'h00, 1'b0, 1'b1, {HI0, S0});
        push_both(9, "top01", 8'h01, 1'b0, 1'b0, 14'h0);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        cycle(9);

        // Down wrap from zero in both radices.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        push_both(1, "bot00", 8'h00, 1'b0, 1'b0, 14'h0);
        push(5, 0, "botwrap", 8'h99, 1'b1, 1'b0, 14'h0);
        push(5, 1, "botwrap", 8'hFF, 1'b1, 1'b0, 14'h0);
        push(6, 0, "botwrp2", 8'h99, 1'b0, 1'b1, {S9, S9});
        push(6, 1, "botwrp2", 8'hFF, 1'b0, 1'b1, {SF, SF});
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(6);

        // Leading-zero display and a zero in the low digit.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h05);
        push(1, 0, "disp05",  8'h05, 1'b0, 1'b0, 14'h0);
        push(2, 0, "disp05h", 8'h50, 1'b0, 1'b1, {HI0, S5});
        push(3, 0, "disp50h", 8'h50, 1'b0, 1'b1, {S5, S0});
        cycle(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h50);
        cycle(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h50);
        cycle(2);

        // Reset mid-count overrides a load and restarts the prescaler.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        push_both(1, "midrst",  8'h00, 1'b0, 1'b1, {S0, S0});
        push_both(2, "midrsth", 8'h00, 1'b0, 1'b1, {HI0, S0});
        push_both(4, "midpre",  8'h00, 1'b0, 1'b0, 14'h0);
        push_both(5, "midstep", 8'h01, 1'b0, 1'b0, 14'h0);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        cycle(6);

        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            cycle(1);
        end
        if (sb.size() > 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL drain: %0d expectations pending, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
